// File: rtl/noc_mesh_router_pkg.sv
// Types and helpers shared by the mesh router and its input FIFOs.
package noc_mesh_router_pkg;
`include "npu_definitions.vh"

   localparam int NUM_PORTS = 5;

   typedef logic [2:0] port_t;

   function automatic port_t next_port(input port_t p);
      return (p == port_t'(NUM_PORTS - 1)) ? port_t'(0) : p + 3'd1;
   endfunction
endpackage

// File: rtl/noc_fifo.sv
// Per-input flit FIFO; head is visible the cycle after push (no fall-through).
// ready is registered and never looks at push, so it is safe to feed upstream.
module noc_fifo
   import noc_mesh_router_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   output logic             ready,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             head_vld
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count, count_nxt;
   logic             do_push, do_pop;

   assign do_push  = push && ready;
   assign do_pop   = pop && head_vld;
   assign head     = mem[rd_ptr];
   assign head_vld = (count != '0);

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + 1'b1;
      else if (!do_push && do_pop)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_dat;
   end

   // ready stays low through reset and rises on the first edge after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         ready <= (count_nxt < DEPTH_C);
      end
   end
endmodule

// File: rtl/npu_definitions.vh
// Shared NPU mesh constants: router port indices and flit field offsets.
// Flit layout is {dest_x, dest_y, payload}, MSB first.
`ifndef NPU_DEFINITIONS_VH
`define NPU_DEFINITIONS_VH

localparam int PORT_L = 0;
localparam int PORT_N = 1;
localparam int PORT_S = 2;
localparam int PORT_E = 3;
localparam int PORT_W = 4;

`define NPU_PAYLOAD_LSB 0
`define NPU_DEST_Y_LSB(dw) (dw)
`define NPU_DEST_X_LSB(dw, cw) ((dw) + (cw))

`endif

// File: rtl/noc_mesh_router.sv
// 5-port XY mesh router: input FIFOs, per-output round-robin arbiter and output register.
// Optional per-output flit/stall counters are enabled with NOC_ROUTER_STATS_EN.
`include "npu_definitions.vh"

module noc_mesh_router
   import noc_mesh_router_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int COORD_W = 3,
   parameter int DEPTH   = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [COORD_W-1:0]                 router_x,
   input  logic [COORD_W-1:0]                 router_y,
   input  logic [5*(DATA_W+2*COORD_W)-1:0]    in_flit,
   input  logic [4:0]                         in_valid,
   output logic [4:0]                         in_ready,
   output logic [5*(DATA_W+2*COORD_W)-1:0]    out_flit,
   output logic [4:0]                         out_valid,
   input  logic [4:0]                         out_ready
`ifdef NOC_ROUTER_STATS_EN
   ,
   output logic [5*16-1:0]                    stat_flits,
   output logic [5*16-1:0]                    stat_stall
`endif
);
   localparam int FLIT_W = DATA_W + 2*COORD_W;
   localparam int DX_LSB = `NPU_DEST_X_LSB(DATA_W, COORD_W);
   localparam int DY_LSB = `NPU_DEST_Y_LSB(DATA_W);

   logic [FLIT_W-1:0]    head      [NUM_PORTS];
   logic [FLIT_W-1:0]    out_dat_q [NUM_PORTS];
   port_t                route     [NUM_PORTS];
   port_t                gnt_idx   [NUM_PORTS];
   port_t                ptr       [NUM_PORTS];
   logic [NUM_PORTS-1:0] head_vld, pop, gnt_vld, out_vld_q;

   function automatic port_t xy_route(input logic [COORD_W-1:0] dx, input logic [COORD_W-1:0] dy,
                                      input logic [COORD_W-1:0] rx, input logic [COORD_W-1:0] ry);
      if (dx > rx) return port_t'(PORT_E);
      if (dx < rx) return port_t'(PORT_W);
      if (dy > ry) return port_t'(PORT_N);
      if (dy < ry) return port_t'(PORT_S);
      return port_t'(PORT_L);
   endfunction

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      noc_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (in_valid[p]),
         .push_dat (in_flit[p*FLIT_W +: FLIT_W]),
         .ready    (in_ready[p]),
         .pop      (pop[p]),
         .head     (head[p]),
         .head_vld (head_vld[p])
      );
      assign route[p] = xy_route(head[p][DX_LSB +: COORD_W], head[p][DY_LSB +: COORD_W],
                                 router_x, router_y);
      assign out_flit[p*FLIT_W +: FLIT_W] = out_dat_q[p];
   end

   assign out_valid = out_vld_q;

   // Each input requests exactly one output, so one grant per input falls out naturally.
   always_comb begin
      int    c;
      port_t ci;
      c       = 0;
      ci      = '0;
      pop     = '0;
      gnt_vld = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         gnt_idx[o] = '0;
         if (!out_vld_q[o] || out_ready[o]) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
               c = int'(ptr[o]) + k;
               if (c >= NUM_PORTS)
                  c = c - NUM_PORTS;
               ci = port_t'(c);
               if (!gnt_vld[o] && head_vld[ci] && route[ci] == port_t'(o)) begin
                  gnt_vld[o] = 1'b1;
                  gnt_idx[o] = ci;
                  pop[ci]    = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q <= '0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            out_dat_q[o] <= '0;
            ptr[o]       <= '0;
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (gnt_vld[o]) begin
               out_dat_q[o] <= head[gnt_idx[o]];
               out_vld_q[o] <= 1'b1;
               ptr[o]       <= next_port(gnt_idx[o]);
            end else if (out_ready[o]) begin
               out_vld_q[o] <= 1'b0;
            end
         end
      end
   end

`ifdef NOC_ROUTER_STATS_EN
   logic [15:0] flits_q [NUM_PORTS];
   logic [15:0] stall_q [NUM_PORTS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            flits_q[o] <= '0;
            stall_q[o] <= '0;
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (out_vld_q[o] && out_ready[o] && flits_q[o] != 16'hFFFF)
               flits_q[o] <= flits_q[o] + 16'd1;
            if (out_vld_q[o] && !out_ready[o] && stall_q[o] != 16'hFFFF)
               stall_q[o] <= stall_q[o] + 16'd1;
         end
      end
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_stat
      assign stat_flits[o*16 +: 16] = flits_q[o];
      assign stat_stall[o*16 +: 16] = stall_q[o];
   end
`endif
endmodule

// File: doc/noc_mesh_router.md
NOC_MESH_ROUTER -- requirements
Module: noc_mesh_router

Interface
- REQ-001 SHALL have parameter DATA_W, default 16, payload width in bits.
- REQ-002 SHALL have parameter COORD_W, default 3, width of each of dest_x and dest_y.
- REQ-003 SHALL have parameter DEPTH, default 4, input FIFO entries per port (power of two, >= 2).
- REQ-004 SHALL define FLIT_W = DATA_W + 2*COORD_W, with flit layout {dest_x, dest_y, payload}, MSB first.
- REQ-005 Port list, in this order:
  - clk  in  1  sole clock, rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - router_x  in  COORD_W  own mesh X coordinate, static after reset.
  - router_y  in  COORD_W  own mesh Y coordinate, static after reset.
  - in_flit  in  5*FLIT_W  input flits; port p occupies slice p.
  - in_valid  in  5  per-input valid.
  - in_ready  out  5  per-input ready.
  - out_flit  out  5*FLIT_W  output flits.
  - out_valid  out  5  per-output valid.
  - out_ready  in  5  per-output downstream ready.
- REQ-006 Port index SHALL be: 0=Local, 1=North, 2=South, 3=East, 4=West.

Function
- REQ-007 A flit SHALL be transferred only on a clock edge where valid and ready are both high, on both inputs and outputs.
- REQ-008 Each input SHALL have a DEPTH-entry FIFO; in_ready[p] SHALL equal (count_p < DEPTH), driven from a register, and SHALL NOT depend on in_valid.
- REQ-009 A FIFO SHALL support push and pop on the same edge; count is unchanged and the entry is not lost.
- REQ-010 Routing SHALL be dimension-order XY on the FIFO head flit, compared unsigned:
  - dest_x > router_x -> East; dest_x < router_x -> West;
  - otherwise dest_y > router_y -> North; dest_y < router_y -> South;
  - otherwise Local.
- REQ-011 U-turns, i.e. output equal to the arrival port, SHALL be allowed and routed normally.
- REQ-012 Each output SHALL have a round-robin arbiter over the inputs whose head flit requests it.
  - The priority pointer SHALL move to winner+1 (mod 5) only on a grant.
  - After reset the pointer SHALL be 0.
- REQ-013 Each output SHALL have a single-entry output register.
  - It accepts a grant when empty, or when out_valid && out_ready on the same edge (full throughput).
  - Otherwise it holds data and valid stable.
- REQ-014 Uncontended latency SHALL be 2 cycles: a flit accepted at edge t SHALL appear on out_valid after edge t+1.
- REQ-015 Each input SHALL be granted at most one output per cycle; each output SHALL accept at most one flit per cycle.
- REQ-016 A blocked output SHALL NOT stall flits from other inputs destined for other outputs; head-of-line blocking within one input FIFO is permitted.
- REQ-017 No flit SHALL be dropped, duplicated or reordered between a given input/output pair.

Reset
- REQ-018 When rst_n is low:
  - all FIFOs and output registers SHALL empty immediately;
  - out_valid SHALL be 0 and out_flit SHALL be 0;
  - in_ready SHALL be 0 during reset and 5'b11111 from the first edge after deassertion;
  - arbiter pointers SHALL be 0.
- REQ-019 Reset asserted mid-transfer SHALL discard all in-flight flits, with no partial output.

Configuration
- REQ-020 With macro NOC_ROUTER_STATS_EN defined:
  - port stat_flits out 5*16 SHALL provide per-output counters, incremented on each output handshake and saturating at 16'hFFFF;
  - port stat_stall out 5*16 SHALL provide per-output counters, incremented each cycle with out_valid && !out_ready, saturating;
  - both counter sets SHALL reset to 0.
- REQ-021 Without NOC_ROUTER_STATS_EN, both ports and all counter logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
- REQ-022 The port-index constants (PORT_L/N/S/E/W) and the flit field offsets SHALL live in the shared header npu_definitions.vh.
- REQ-023 The input FIFO SHALL be the sub-module noc_fifo (params WIDTH, DEPTH), instantiated 5 times.

Verification
- REQ-024 Router at (2,2), single flit dest (2,2) payload 16'hA5A5 on Local: out_valid[0] rises 2 cycles later with identical flit.
- REQ-025 At (2,2), dests (4,1), (0,3), (2,5), (2,0): the flits exit on East, West, North and South respectively.
- REQ-026 N, S, E and W all send continuous flits to Local: grants rotate N,S,E,W,N...; each input receives 25% +/-1 over 100 flits.
- REQ-027 out_ready[3]=0 with 6 flits sent to East on Local: in_ready[0] drops after DEPTH+1 accepted flits; a concurrent North->Local stream continues unblocked; after ready rises all 6 flits arrive in order.
- REQ-028 Reset pulsed while 3 flits are buffered: out_valid=0 and FIFOs empty immediately; no stale flit appears after release.
- REQ-029 With NOC_ROUTER_STATS_EN, 10 Local flits with 3 stall cycles: stat_flits[0]=10 and stat_stall[0]=3.
